// File: rtl/fifo_stream_reader.sv
// Read-side controller for a sync FIFO in normal read mode: drains the FIFO into a
// 2-entry skid buffer and presents a valid/ready stream, counting delivered beats.
module fifo_stream_reader #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  output logic             fifo_rd_en,
  input  logic [DW-1:0]    fifo_rd_data,
  input  logic             fifo_empty,
  output logic             m_valid,
  output logic [DW-1:0]    m_data,
  input  logic             m_ready,
  output logic [1:0]       buf_cnt,
  output logic [CNT_W-1:0] beat_cnt
);

  logic [DW-1:0] buf_mem [2];
  logic          hd;
  logic          inf;
  logic          run;
  logic [1:0]    occ;
  logic          pop;
  logic          cap;
  logic          wr_idx;
  logic [2:0]    pending;
  logic [1:0]    occ_nxt;

  assign pop = m_valid & m_ready;
  assign cap = inf & ~flush;

  // Slots committed once the in-flight read lands; only read when a slot is guaranteed.
  assign pending    = {1'b0, occ} + {2'b00, inf} - {2'b00, pop};
  assign fifo_rd_en = run & ~flush & ~fifo_empty & (pending < 3'd2);

  assign wr_idx  = hd ^ occ[0];
  assign occ_nxt = occ + {1'b0, cap} - {1'b0, pop};

  assign m_valid = (occ != 2'd0);
  assign m_data  = buf_mem[hd];
  assign buf_cnt = occ;

  // Control: run gate, in-flight flag, head pointer, occupancy, beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      inf      <= 1'b0;
      hd       <= 1'b0;
      occ      <= 2'd0;
      beat_cnt <= '0;
    end else begin
      run      <= 1'b1;
      beat_cnt <= beat_cnt + {{(CNT_W-1){1'b0}}, pop};
      if (flush) begin
        inf <= 1'b0;
        hd  <= 1'b0;
        occ <= 2'd0;
      end else begin
        inf <= fifo_rd_en;
        occ <= occ_nxt;
        if (pop) hd <= ~hd;
      end
    end
  end

  // Data capture: returning read data lands behind the current head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
    end else if (cap) begin
      buf_mem[wr_idx] <= fifo_rd_data;
    end
  end

endmodule
